// File: rtl/behavioral.sv
// Registered full adder: q = a + b + c at WIDTH+1 bits, one-cycle latency.
// Define BEHAVIORAL_OVF_EN to add a registered signed-overflow output, ovf.
module behavioral #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
`ifdef BEHAVIORAL_OVF_EN
   output logic             ovf,
`endif
   output logic [WIDTH:0]   q
);

   logic [WIDTH:0] sum;

   always_comb begin
      sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else begin
         q <= sum;
      end
   end

`ifdef BEHAVIORAL_OVF_EN
   // Overflow: both operands share a sign and the sum's sign bit disagrees with it.
   logic ovf_next;

   always_comb begin
      ovf_next = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= 1'b0;
      end else begin
         ovf <= ovf_next;
      end
   end
`endif

endmodule

// File: tb/tb_behavioral.sv
// Self-checking bench for behavioral: a WIDTH=1 and a WIDTH=8 instance,
// table-driven vectors fed through expected-result scoreboards.
module tb_behavioral;

   logic       clk;
   logic       rst1, rst8;
   logic       a1, b1, c1;
   logic [1:0] q1;
   logic [7:0] a8, b8;
   logic       c8;
   logic [8:0] q8;
`ifdef BEHAVIORAL_OVF_EN
   logic       ovf1, ovf8;
`endif

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   typedef struct {
      logic [8:0] q;
      logic       ovf;
   } exp_t;

   exp_t sb1[$];
   exp_t sb8[$];

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      logic [8:0] q;
      logic       ovf;
   } vec_t;

   vec_t v1[9];
   vec_t v8[8];

   behavioral #(.WIDTH(1)) dut1 (
      .clk(clk),
      .rst(rst1),
      .a(a1),
      .b(b1),
      .c(c1),
`ifdef BEHAVIORAL_OVF_EN
      .ovf(ovf1),
`endif
      .q(q1)
   );

   behavioral #(.WIDTH(8)) dut8 (
      .clk(clk),
      .rst(rst8),
      .a(a8),
      .b(b8),
      .c(c8),
`ifdef BEHAVIORAL_OVF_EN
      .ovf(ovf8),
`endif
      .q(q8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) begin
         n_pass++;
      end else begin
         $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic step1(input logic r, input logic aa, input logic bb, input logic cc,
                        input logic [1:0] e, input string nm);
      exp_t ex;
      @(negedge clk);
      rst1 = r; a1 = aa; b1 = bb; c1 = cc;
      ex.q = {7'd0, e};
      ex.ovf = 1'b0;
      sb1.push_back(ex);
      @(posedge clk);
      #1;
      ex = sb1.pop_front();
      check(nm, {62'd0, q1}, {55'd0, ex.q});
   endtask

   task automatic step8(input logic r, input logic [7:0] aa, input logic [7:0] bb,
                        input logic cc, input logic [8:0] e, input logic eo, input string nm);
      exp_t ex;
      @(negedge clk);
      rst8 = r; a8 = aa; b8 = bb; c8 = cc;
      ex.q = e;
      ex.ovf = eo;
      sb8.push_back(ex);
      @(posedge clk);
      #1;
      ex = sb8.pop_front();
      check(nm, {55'd0, q8}, {55'd0, ex.q});
`ifdef BEHAVIORAL_OVF_EN
      check({nm, "_ovf"}, {63'd0, ovf8}, {63'd0, ex.ovf});
`endif
   endtask

   initial begin
      // Full-adder truth table, then back to 000.
      v1[0] = '{8'd0, 8'd0, 1'b0, 9'd0, 1'b0};
      v1[1] = '{8'd0, 8'd0, 1'b1, 9'd1, 1'b0};
      v1[2] = '{8'd0, 8'd1, 1'b0, 9'd1, 1'b0};
      v1[3] = '{8'd0, 8'd1, 1'b1, 9'd2, 1'b0};
      v1[4] = '{8'd1, 8'd0, 1'b0, 9'd1, 1'b0};
      v1[5] = '{8'd1, 8'd0, 1'b1, 9'd2, 1'b0};
      v1[6] = '{8'd1, 8'd1, 1'b0, 9'd2, 1'b0};
      v1[7] = '{8'd1, 8'd1, 1'b1, 9'd3, 1'b0};
      v1[8] = '{8'd0, 8'd0, 1'b0, 9'd0, 1'b0};

      v8[0] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0};
      v8[1] = '{8'h80, 8'h80, 1'b0, 9'h100, 1'b1};
      v8[2] = '{8'h7F, 8'h00, 1'b1, 9'h080, 1'b1};
      v8[3] = '{8'h01, 8'h01, 1'b0, 9'h002, 1'b0};
      v8[4] = '{8'h00, 8'h00, 1'b0, 9'h000, 1'b0};
      v8[5] = '{8'h7F, 8'h7F, 1'b0, 9'h0FE, 1'b1};
      v8[6] = '{8'h0F, 8'hF1, 1'b0, 9'h100, 1'b0};
      v8[7] = '{8'hC0, 8'hBF, 1'b1, 9'h180, 1'b0};

      rst1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
      rst8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;

      // Reset held two edges with all inputs high, then released.
      step1(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, "reset_edge1");
      step1(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, "reset_edge2");
      step8(1'b1, 8'hFF, 8'hFF, 1'b1, 9'h000, 1'b0, "reset8");
      step1(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, "reset_release");

      for (int i = 0; i < 9; i++) begin
         for (int k = 0; k < 10; k++) begin
            step1(1'b0, v1[i].a[0], v1[i].b[0], v1[i].c, v1[i].q[1:0],
                  $sformatf("sweep_%0d_cyc%0d", i, k));
         end
      end

      // Input change mid-cycle must not reach q before the next edge.
      step1(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, "latency_pre");
      #1;
      a1 = 1'b1;
      #2;
      check("latency_hold", {62'd0, q1}, 64'd0);
      step1(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, "latency_load");

      step1(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, "midrst_pre");
      step1(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, "midrst_clear");
      step1(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, "midrst_release");

      for (int i = 0; i < 8; i++) begin
         step8(1'b0, v8[i].a, v8[i].b, v8[i].c, v8[i].q, v8[i].ovf,
               $sformatf("w8_vec%0d", i));
      end
      step8(1'b1, 8'h80, 8'h80, 1'b0, 9'h000, 1'b0, "w8_midrst");
      step8(1'b0, 8'h80, 8'h80, 1'b0, 9'h100, 1'b1, "w8_release");

      check("sb_drained", {62'd0, 32'(sb1.size()) == 0, 32'(sb8.size()) == 0 ? 1'b1 : 1'b0}, 64'd3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
